// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio playback path.
package flash_audio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_HALF0,
    S_HALF1,
    S_STEP,
    S_SETTLE
  } reader_state_t;

  localparam logic [31:0] FLASH_LAST_ADDR = 32'h7FFFF;
  localparam int unsigned SAMPLE_W        = 16;
  localparam int unsigned SETTLE_CYCLES   = 2;

endpackage

// File: rtl/flash_sample_reader.sv
// Fetches one flash word per address and plays its two 16-bit halves on
// successive sample ticks, then requests the next address.
module flash_sample_reader #(
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addr,
  input  logic                backward,
  input  logic                play,
  input  logic                sample_tick,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_address,
  output logic [3:0]          flash_byteenable,
  input  logic                flash_waitrequest,
  input  logic                flash_readdatavalid,
  input  logic [DATA_W-1:0]   flash_readdata,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                addr_step,
  output logic                underrun
);
  import flash_audio_pkg::reader_state_t;
  import flash_audio_pkg::S_IDLE;
  import flash_audio_pkg::S_READ;
  import flash_audio_pkg::S_WAIT;
  import flash_audio_pkg::S_HALF0;
  import flash_audio_pkg::S_HALF1;
  import flash_audio_pkg::S_STEP;
  import flash_audio_pkg::S_SETTLE;
  import flash_audio_pkg::SETTLE_CYCLES;

  reader_state_t         state_q, state_d;
  logic                  flash_read_q, flash_read_d;
  logic [ADDR_W-1:0]     flash_address_q, flash_address_d;
  logic                  dir_q, dir_d;
  logic [DATA_W-1:0]     word_q, word_d;
  logic [SAMPLE_W-1:0]   sample_out_q, sample_out_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  addr_step_q, addr_step_d;
  logic                  underrun_q, underrun_d;
  logic [1:0]            settle_q, settle_d;
  logic                  tick_play;
  logic [SAMPLE_W-1:0]   half_lo, half_hi;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_W];
  assign tick_play        = sample_tick & play;
  assign half_lo          = word_q[SAMPLE_W-1:0];
  assign half_hi          = word_q[DATA_W-1:SAMPLE_W];

  always_comb begin
    state_d         = state_q;
    flash_read_d    = flash_read_q;
    flash_address_d = flash_address_q;
    dir_d           = dir_q;
    word_d          = word_q;
    sample_out_d    = sample_out_q;
    sample_valid_d  = 1'b0;
    addr_step_d     = 1'b0;
    underrun_d      = underrun_q;
    settle_d        = settle_q;

    unique case (state_q)
      S_IDLE: begin
        if (play) begin
          flash_address_d = addr[ADDR_W-1:0];
          dir_d           = backward;
          flash_read_d    = 1'b1;
          state_d         = S_READ;
        end
      end
      S_READ: begin
        if (!flash_waitrequest) begin
          flash_read_d = 1'b0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flash_readdatavalid) begin
          word_d  = flash_readdata;
          state_d = S_HALF0;
        end
      end
      S_HALF0: begin
        if (tick_play) begin
          sample_out_d   = dir_q ? half_hi : half_lo;
          sample_valid_d = 1'b1;
          state_d        = S_HALF1;
        end
      end
      S_HALF1: begin
        if (tick_play) begin
          sample_out_d   = dir_q ? half_lo : half_hi;
          sample_valid_d = 1'b1;
          addr_step_d    = 1'b1;
          state_d        = S_STEP;
        end
      end
      S_STEP: begin
        settle_d = 2'(SETTLE_CYCLES - 1);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Only the two playing states can consume a tick; anywhere else it is lost.
    if (tick_play && !(state_q inside {S_HALF0, S_HALF1})) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      flash_read_q    <= 1'b0;
      flash_address_q <= '0;
      dir_q           <= 1'b0;
      word_q          <= '0;
      sample_out_q    <= '0;
      sample_valid_q  <= 1'b0;
      addr_step_q     <= 1'b0;
      underrun_q      <= 1'b0;
      settle_q        <= '0;
    end else begin
      state_q         <= state_d;
      flash_read_q    <= flash_read_d;
      flash_address_q <= flash_address_d;
      dir_q           <= dir_d;
      word_q          <= word_d;
      sample_out_q    <= sample_out_d;
      sample_valid_q  <= sample_valid_d;
      addr_step_q     <= addr_step_d;
      underrun_q      <= underrun_d;
      settle_q        <= settle_d;
    end
  end

  assign flash_read       = flash_read_q;
  assign flash_address    = flash_address_q;
  assign flash_byteenable = 4'b1111;
  assign sample_out       = sample_out_q;
  assign sample_valid     = sample_valid_q;
  assign addr_step        = addr_step_q;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed plus randomized bench for flash_sample_reader with a flash slave
// model and an address-controller model that advances on addr_step.
module tb_flash_sample_reader;
  import flash_audio_pkg::*;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SW     = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       addr;
  logic              backward = 1'b0;
  logic              play = 1'b0;
  logic              sample_tick = 1'b0;
  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic [3:0]        flash_byteenable;
  logic              flash_waitrequest = 1'b1;
  logic              flash_readdatavalid = 1'b0;
  logic [DATA_W-1:0] flash_readdata = '0;
  logic [SW-1:0]     sample_out;
  logic              sample_valid;
  logic              addr_step;
  logic              underrun;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // flash slave and address controller model state
  int unsigned       ws_cfg = 0, lat_cfg = 1, wait_left = 0, pend = 0;
  logic [31:0]       mem_data = '0;
  int unsigned       read_count = 0, step_count = 0;
  logic [ADDR_W-1:0] last_read_addr = '0;
  logic [ADDR_W-1:0] ctrl_addr = '0;
  logic [8:0]        addr_hi = '0;
  bit                inject_stale = 1'b0;

  assign addr = {addr_hi, ctrl_addr};

  flash_sample_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .addr                (addr),
    .backward            (backward),
    .play                (play),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_byteenable    (flash_byteenable),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .sample_out          (sample_out),
    .sample_valid        (sample_valid),
    .addr_step           (addr_step),
    .underrun            (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic b);
    if (b) return (a == '0) ? ADDR_W'(FLASH_LAST_ADDR) : a - 1'b1;
    return (a == ADDR_W'(FLASH_LAST_ADDR)) ? '0 : a + 1'b1;
  endfunction

  always @(negedge clk) begin
    flash_readdatavalid = 1'b0;
    if (reset) begin
      pend = 0;
      wait_left = ws_cfg;
      flash_waitrequest = 1'b1;
    end else begin
      if (inject_stale) begin
        flash_readdatavalid = 1'b1;
        flash_readdata = 32'h12345678;
        inject_stale = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata = mem_data;
        end
      end
      if (flash_read) begin
        if (wait_left > 0) begin
          flash_waitrequest = 1'b1;
          wait_left--;
        end else begin
          flash_waitrequest = 1'b0;
          read_count++;
          last_read_addr = flash_address;
          pend = lat_cfg;
          wait_left = ws_cfg;
        end
      end else begin
        flash_waitrequest = 1'b1;
        wait_left = ws_cfg;
      end
    end
    if (addr_step) begin
      step_count++;
      ctrl_addr = next_addr(ctrl_addr, backward);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; the tick lasts one clock.
  task automatic do_tick(input logic p, input logic exp_v, input logic [SW-1:0] exp_s, input string tag);
    play = p;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check({tag, "_valid"}, 32'(sample_valid), 32'(exp_v));
    check({tag, "_sample"}, 32'(sample_out), 32'(exp_s));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(sample_valid), 32'd0);
  endtask

  task automatic play_word(input logic [31:0] data, input logic bwd, input int unsigned ws,
                           input int unsigned lat, input int unsigned gap,
                           input logic [ADDR_W-1:0] exp_addr, input logic exp_und, input string tag);
    logic [SW-1:0] hq[$];
    int unsigned rc, sc;
    if (bwd) hq = '{data[31:16], data[15:0]};
    else     hq = '{data[15:0], data[31:16]};
    mem_data = data;
    backward = bwd;
    ws_cfg = ws;
    lat_cfg = lat;
    rc = read_count;
    sc = step_count;
    play = 1'b1;
    repeat (ws + lat + 5) @(negedge clk);
    #1;
    check({tag, "_reads"}, read_count, rc + 1);
    check({tag, "_addr"}, 32'(last_read_addr), 32'(exp_addr));
    check({tag, "_nostep"}, step_count, sc);
    do_tick(1'b1, 1'b1, hq.pop_front(), {tag, "_h0"});
    repeat (gap) @(negedge clk);
    do_tick(1'b1, 1'b1, hq.pop_front(), {tag, "_h1"});
    play = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_step"}, step_count, sc + 1);
    check({tag, "_underrun"}, 32'(underrun), 32'(exp_und));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] exp_a;
    logic              b;
    int unsigned       rc, sc;

    ctrl_addr = 23'h10;
    addr_hi = 9'h1A5;
    repeat (3) @(negedge clk);
    check("rst_read", 32'(flash_read), 32'd0);
    check("rst_addr", 32'(flash_address), 32'd0);
    check("rst_sample", 32'(sample_out), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_step", 32'(addr_step), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("byteenable", 32'(flash_byteenable), 32'hF);
    reset = 1'b0;
    @(negedge clk);

    play_word(32'hAAAA5555, 1'b0, 2, 1, 3, 23'h10, 1'b0, "fwd");
    play_word(32'hAAAA5555, 1'b1, 0, 1, 2, 23'h11, 1'b0, "bwd");

    // pause inside the second half
    mem_data = 32'h13579BDF;
    backward = 1'b0;
    ws_cfg = 1;
    lat_cfg = 2;
    sc = step_count;
    play = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("pause_addr", 32'(last_read_addr), 32'h10);
    do_tick(1'b1, 1'b1, 16'h9BDF, "pause_h0");
    for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b0, 16'h9BDF, "paused");
    check("pause_underrun", 32'(underrun), 32'd0);
    check("pause_nostep", step_count, sc);
    do_tick(1'b1, 1'b1, 16'h1357, "resume_h1");
    play = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("pause_step", step_count, sc + 1);

    // tick while the word is still in flight
    mem_data = 32'hCAFEF00D;
    ws_cfg = 3;
    lat_cfg = 3;
    play = 1'b1;
    repeat (5) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("und_valid", 32'(sample_valid), 32'd0);
    check("und_set", 32'(underrun), 32'd1);
    repeat (4) @(negedge clk);
    do_tick(1'b1, 1'b1, 16'hF00D, "und_h0");
    do_tick(1'b1, 1'b1, 16'hCAFE, "und_h1");
    play = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("und_addr", 32'(last_read_addr), 32'h11);
    check("und_sticky", 32'(underrun), 32'd1);

    // reset in the middle of a stalled read
    ws_cfg = 4;
    lat_cfg = 1;
    mem_data = 32'hDEADBEEF;
    play = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_read", 32'(flash_read), 32'd1);
    reset = 1'b1;
    play = 1'b0;
    @(negedge clk);
    check("mrst_read", 32'(flash_read), 32'd0);
    check("mrst_addr", 32'(flash_address), 32'd0);
    check("mrst_sample", 32'(sample_out), 32'd0);
    check("mrst_step", 32'(addr_step), 32'd0);
    check("mrst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    inject_stale = 1'b1;
    repeat (5) @(negedge clk);
    check("stale_sample", 32'(sample_out), 32'd0);
    check("stale_read", 32'(flash_read), 32'd0);
    sample_tick = 1'b0;

    // address wrap supplied by the controller
    ctrl_addr = ADDR_W'(FLASH_LAST_ADDR);
    rc = read_count;
    play_word(32'h0BAD0C0D, 1'b0, 1, 1, 1, ADDR_W'(FLASH_LAST_ADDR), 1'b0, "wrap_last");
    play_word(32'h600DF00D, 1'b1, 0, 2, 0, 23'h0, 1'b0, "wrap_zero");
    play_word(32'h89ABCDEF, 1'b0, 2, 1, 1, ADDR_W'(FLASH_LAST_ADDR), 1'b0, "wrap_back");
    check("wrap_reads", read_count, rc + 3);

    exp_a = ctrl_addr;
    for (int unsigned k = 0; k < 8; k++) begin
      b = 1'($urandom_range(0, 1));
      addr_hi = 9'($urandom);
      play_word($urandom, b, $urandom_range(0, 3), $urandom_range(1, 3),
                $urandom_range(0, 5), exp_a, 1'b0, $sformatf("rnd%0d", k));
      exp_a = next_addr(exp_a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
